bin2bcd_display_feed: RTL and testbench

- Sequential binary-to-BCD converter that sits directly downstream of the ALU result bus (writeBus) and upstream of the LCD controller.
- On a start strobe it captures a 16-bit result and converts it to five decimal digits using iterative shift-and-add-3 (double dabble), one shift per clock.
- Presents registered BCD digits, a sign flag and a leading-zero blank mask, so the LCD controller can print decimal instead of hex.

---
 rtl/bin2bcd_display_feed_if.sv | 24 ++
 rtl/bin2bcd_display_feed.sv | 122 ++++++++++++
 tb/tb_bin2bcd_display_feed.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_display_feed_if.sv
// Handshake and result bundle between the ALU write bus and the BCD feed.
// The master drives start/value; the slave returns status and digits.
interface bin2bcd_display_feed_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, value,
        input  busy, done, bcd, neg, blank
    );

    modport slave (
        input  start, value,
        output busy, done, bcd, neg, blank
    );
endinterface

// File: rtl/bin2bcd_display_feed.sv
// Sequential double-dabble converter feeding decimal digits to the LCD.
// One shift per clock; registered digits, sign and leading-zero mask.
module bin2bcd_display_feed #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    bin2bcd_display_feed_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     scratch;
    logic [CW-1:0]     step;
    logic              neg_cap;

    logic              sign_in;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_nxt;
    logic [WIDTH-1:0]  shreg_nxt;
    logic              last;
    logic [DIGITS-1:0] blank_nxt;

    logic              done_r;
    logic              neg_r;
    logic [BW-1:0]     bcd_r;
    logic [DIGITS-1:0] blank_r;

    // Two's-complement negate is exact in WIDTH bits for the most negative value.
    always_comb begin
        sign_in = SIGNED_MODE ? bus.value[WIDTH-1] : 1'b0;
        mag     = sign_in ? (~bus.value + WIDTH'(1)) : bus.value;
    end

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
        last = (step == CW'(WIDTH - 1));
    end

    always_comb begin
        logic lead;
        lead      = 1'b1;
        blank_nxt = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            lead         = lead & (scratch_nxt[4*d +: 4] == 4'd0);
            blank_nxt[d] = lead;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = SHIFT;
            SHIFT: if (last)      state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            scratch <= '0;
            step    <= '0;
            neg_cap <= 1'b0;
            done_r  <= 1'b0;
            neg_r   <= 1'b0;
            bcd_r   <= '0;
            blank_r <= BLANK_RST;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= mag;
                        scratch <= '0;
                        step    <= '0;
                        neg_cap <= sign_in;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    step    <= step + CW'(1);
                    if (last) begin
                        bcd_r   <= scratch_nxt;
                        blank_r <= blank_nxt;
                        neg_r   <= neg_cap;
                        done_r  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == SHIFT);
    assign bus.done  = done_r;
    assign bus.bcd   = bcd_r;
    assign bus.neg   = neg_r;
    assign bus.blank = blank_r;
endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Directed bench: one unsigned and one signed converter on a shared clock.
// Expected digits are written out by hand or from a decimal reference.
module tb_bin2bcd_display_feed;
    logic clk;
    logic reset;

    bin2bcd_display_feed_if #(.WIDTH(16), .DIGITS(5)) bus0 ();
    bin2bcd_display_feed_if #(.WIDTH(16), .DIGITS(5)) bus1 ();

    bin2bcd_display_feed #(.WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bin2bcd_display_feed #(.WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit sel = 1'b0;
    logic [19:0] last_bcd [2];

    logic        o_busy;
    logic        o_done;
    logic [19:0] o_bcd;
    logic        o_neg;
    logic [4:0]  o_blank;

    always_comb begin
        o_busy  = sel ? bus1.busy  : bus0.busy;
        o_done  = sel ? bus1.done  : bus0.done;
        o_bcd   = sel ? bus1.bcd   : bus0.bcd;
        o_neg   = sel ? bus1.neg   : bus0.neg;
        o_blank = sel ? bus1.blank : bus0.blank;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] v);
        if (sel) begin
            bus1.start = st;
            bus1.value = v;
        end else begin
            bus0.start = st;
            bus0.value = v;
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called at #1 after an edge with the selected DUT idle.
    task automatic run(input bit s, input logic [15:0] v,
                       input logic [19:0] e_bcd, input logic [4:0] e_blank,
                       input logic e_neg, input string tag);
        int n;
        int nbusy;
        bit hold_ok;
        bit got;
        sel = s;
        drive(1'b1, v);
        @(posedge clk);
        #1;
        drive(1'b0, ~v);
        n = 1;
        nbusy = o_busy ? 1 : 0;
        hold_ok = 1'b1;
        got = 1'b0;
        if (o_bcd !== last_bcd[s]) hold_ok = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (o_done) begin
                got = 1'b1;
                break;
            end
            if (o_busy) nbusy++;
            if (o_bcd !== last_bcd[s]) hold_ok = 1'b0;
        end
        chk({tag, "/done_seen"}, 32'(got), 32'd1);
        chk({tag, "/latency"}, 32'(n), 32'd17);
        chk({tag, "/busy_cycles"}, 32'(nbusy), 32'd16);
        chk({tag, "/busy_at_done"}, 32'(o_busy), 32'd0);
        chk({tag, "/hold"}, 32'(hold_ok), 32'd1);
        chk({tag, "/bcd"}, 32'(o_bcd), 32'(e_bcd));
        chk({tag, "/blank"}, 32'(o_blank), 32'(e_blank));
        chk({tag, "/neg"}, 32'(o_neg), 32'(e_neg));
        @(posedge clk);
        #1;
        chk({tag, "/done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "/bcd_held"}, 32'(o_bcd), 32'(e_bcd));
        last_bcd[s] = e_bcd;
    endtask

    initial begin
        bus0.start = 1'b0;
        bus0.value = '0;
        bus1.start = 1'b0;
        bus1.value = '0;
        last_bcd[0] = '0;
        last_bcd[1] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst/busy", 32'(o_busy), 32'd0);
            chk("rst/done", 32'(o_done), 32'd0);
            chk("rst/bcd", 32'(o_bcd), 32'h0);
            chk("rst/neg", 32'(o_neg), 32'd0);
            chk("rst/blank", 32'(o_blank), 32'b11110);
        end

        run(1'b0, 16'd12345, 20'h12345, 5'b00000, 1'b0, "u12345");
        run(1'b0, 16'd0,     20'h00000, 5'b11110, 1'b0, "u0");
        run(1'b0, 16'hFFFF,  20'h65535, 5'b00000, 1'b0, "uFFFF");
        run(1'b0, 16'd100,   20'h00100, 5'b11000, 1'b0, "u100");
        run(1'b0, 16'd500,   20'h00500, 5'b11000, 1'b0, "u500");

        run(1'b1, 16'hFFFF,  20'h00001, 5'b11110, 1'b1, "sFFFF");
        run(1'b1, 16'h8000,  20'h32768, 5'b00000, 1'b1, "s8000");
        run(1'b1, 16'd42,    20'h00042, 5'b11100, 1'b0, "s42");
        run(1'b1, 16'd0,     20'h00000, 5'b11110, 1'b0, "s0");
        run(1'b1, 16'hFF9C,  20'h00100, 5'b11000, 1'b1, "sneg100");

        // start held high, value changing every cycle
        begin
            int busy_m;
            int ndone;
            logic [15:0] pend;
            logic [15:0] v;
            bit exp_done;
            sel = 1'b0;
            busy_m = 0;
            ndone = 0;
            pend = '0;
            for (int c = 0; c < 51; c++) begin
                v = 16'(c * 1237 + 11);
                drive(1'b1, v);
                @(posedge clk);
                #1;
                exp_done = 1'b0;
                if (busy_m == 0) begin
                    pend = v;
                    busy_m = 16;
                end else begin
                    busy_m--;
                    exp_done = (busy_m == 0);
                end
                if (o_done) ndone++;
                chk("b2b/done", 32'(o_done), 32'(exp_done));
                if (exp_done)
                    chk("b2b/bcd", 32'(o_bcd), 32'(to_bcd(32'(pend))));
            end
            drive(1'b0, 16'd0);
            chk("b2b/ndone", 32'(ndone), 32'd3);
            last_bcd[0] = to_bcd(32'(pend));
        end

        // reset lands on the edge performing step 8 of a 9999 conversion
        begin
            int nd;
            sel = 1'b0;
            @(posedge clk);
            #1;
            drive(1'b1, 16'd9999);
            @(posedge clk);
            #1;
            drive(1'b0, 16'd0);
            repeat (7) @(posedge clk);
            #1;
            chk("abort/busy_before", 32'(o_busy), 32'd1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            chk("abort/busy", 32'(o_busy), 32'd0);
            chk("abort/done", 32'(o_done), 32'd0);
            chk("abort/bcd", 32'(o_bcd), 32'h0);
            chk("abort/blank", 32'(o_blank), 32'b11110);
            nd = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                if (o_done) nd++;
            end
            chk("abort/no_done", 32'(nd), 32'd0);
            last_bcd[0] = '0;
            last_bcd[1] = '0;
        end

        run(1'b0, 16'd7, 20'h00007, 5'b11110, 1'b0, "u7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
